// File: rtl/lut_table_loader_if.sv
// rtl/lut_table_loader_if.sv - config stream, status and lookup signals of the LUT table loader
interface lut_table_loader_if #(
    parameter int IN_W  = 6,
    parameter int OUT_W = 1
);
    logic             load_start;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [OUT_W-1:0] cfg_data;
    logic             cfg_last;
    logic             busy;
    logic             loaded;
    logic             err_len;
    logic             q_valid;
    logic [IN_W-1:0]  q_addr;
    logic             r_valid;
    logic [OUT_W-1:0] r_data;
    logic [OUT_W-1:0] cksum;

    modport master (
        output load_start, cfg_valid, cfg_data, cfg_last, q_valid, q_addr,
        input  cfg_ready, busy, loaded, err_len, r_valid, r_data, cksum
    );

    modport slave (
        input  load_start, cfg_valid, cfg_data, cfg_last, q_valid, q_addr,
        output cfg_ready, busy, loaded, err_len, r_valid, r_data, cksum
    );
endinterface

// File: rtl/lut_table_loader.sv
// rtl/lut_table_loader.sv - run-time loadable neuron truth table with registered lookups
// Optional LUT_CKSUM_EN: XOR checksum of the last successfully loaded table on cksum.
module lut_table_loader #(
    parameter int IN_W  = 6,
    parameter int OUT_W = 1
) (
    input logic            clk,
    input logic            rst_n,
    lut_table_loader_if.slave bus
);
    localparam int              DEPTH    = 2 ** IN_W;
    localparam logic [IN_W:0]   LAST_PTR = (IN_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t           state, state_nxt;
    logic [IN_W:0]    wr_ptr;
    logic             loaded;
    logic             err_len;
    logic             r_valid;
    logic [OUT_W-1:0] r_data;
    logic [OUT_W-1:0] mem [DEPTH];

    logic hs;
    logic at_end;
    logic wr_en;
    logic done_ok;
    logic done_err;

    assign hs     = bus.cfg_valid & (state == LOAD);
    assign at_end = (wr_ptr == LAST_PTR);

    // A restart takes priority over any handshake presented in the same cycle.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        done_ok   = 1'b0;
        done_err  = 1'b0;
        case (state)
            IDLE, READY: begin
                if (bus.load_start) state_nxt = LOAD;
            end
            LOAD: begin
                if (bus.load_start) begin
                    state_nxt = LOAD;
                end else if (hs) begin
                    wr_en = 1'b1;
                    if (at_end && bus.cfg_last) begin
                        done_ok   = 1'b1;
                        state_nxt = READY;
                    end else if (at_end || bus.cfg_last) begin
                        done_err  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            loaded  <= 1'b0;
            err_len <= 1'b0;
        end else begin
            state <= state_nxt;
            if (bus.load_start) begin
                wr_ptr  <= '0;
                loaded  <= 1'b0;
                err_len <= 1'b0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + (IN_W + 1)'(1);
                if (done_ok) begin
                    loaded  <= 1'b1;
                    err_len <= 1'b0;
                end
                if (done_err) begin
                    loaded  <= 1'b0;
                    err_len <= 1'b1;
                end
            end
        end
    end

    // Table storage is deliberately unreset; loaded gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[IN_W-1:0]] <= bus.cfg_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= bus.q_valid & loaded;
            if (bus.q_valid && loaded) r_data <= mem[bus.q_addr];
        end
    end

`ifdef LUT_CKSUM_EN
    logic [OUT_W-1:0] xor_acc;
    logic [OUT_W-1:0] cksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_acc <= '0;
            cksum_q <= '0;
        end else begin
            if (bus.load_start)  xor_acc <= '0;
            else if (wr_en)      xor_acc <= xor_acc ^ bus.cfg_data;
            if (done_ok)         cksum_q <= xor_acc ^ bus.cfg_data;
        end
    end

    assign bus.cksum = cksum_q;
`else
    assign bus.cksum = '0;
`endif

    assign bus.cfg_ready = (state == LOAD);
    assign bus.busy      = (state == LOAD);
    assign bus.loaded    = loaded;
    assign bus.err_len   = err_len;
    assign bus.r_valid   = r_valid;
    assign bus.r_data    = r_data;
endmodule

// File: tb/tb_lut_table_loader.sv
// tb/tb_lut_table_loader.sv - scoreboard bench for lut_table_loader
module tb_lut_table_loader;
    localparam int IN_W  = 6;
    localparam int OUT_W = 1;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lut_table_loader_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    lut_table_loader #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] sb_exp;
    logic [OUT_W-1:0] pattern [DEPTH];
    logic [OUT_W-1:0] model [DEPTH];
    logic [OUT_W-1:0] cur_ck = '0;
    bit               model_loaded = 1'b0;
    int               rv_total = 0;
    int               rv_rises = 0;
    logic             rv_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.r_valid === 1'b1) begin
            rv_total++;
            if (!rv_prev) rv_rises++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL r_valid_unexpected got r_valid=1 expected 0 (no request pending)");
            end else begin
                sb_exp = exp_q.pop_front();
                if (bus.r_data !== sb_exp) begin
                    errors++;
                    $display("FAIL r_data got %0h expected %0h", bus.r_data, sb_exp);
                end
            end
        end
        rv_prev = (bus.r_valid === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic query(input logic [IN_W-1:0] a);
        bus.q_valid = 1'b1;
        bus.q_addr  = a;
        if (model_loaded) exp_q.push_back(model[a]);
        tick();
        bus.q_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending results expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic start_load();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic send_words(input int nwords, input int last_idx);
        for (int i = 0; i < nwords; i++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = pattern[i];
            bus.cfg_last  = (i == last_idx);
            tick();
        end
        bus.cfg_valid = 1'b0;
        bus.cfg_last  = 1'b0;
    endtask

    function automatic logic [OUT_W-1:0] pattern_xor();
        logic [OUT_W-1:0] x;
        x = '0;
        for (int i = 0; i < DEPTH; i++) x = x ^ pattern[i];
        return x;
    endfunction

    task automatic commit_model();
        for (int i = 0; i < DEPTH; i++) model[i] = pattern[i];
        model_loaded = 1'b1;
`ifdef LUT_CKSUM_EN
        cur_ck = pattern_xor();
`else
        cur_ck = '0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({bus.cfg_ready, bus.busy, bus.loaded, bus.err_len, bus.r_valid} !== 5'b0 ||
            bus.r_data !== '0 || bus.cksum !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b busy=%b ld=%b err=%b rv=%b rd=%h ck=%h expected all 0",
                     bus.cfg_ready, bus.busy, bus.loaded, bus.err_len, bus.r_valid, bus.r_data, bus.cksum);
        end
        rst_n = 1'b1;
        tick();
        repeat (3) query(6'h1C);
        drain();
        checks++;
        if (bus.loaded !== 1'b0 || bus.cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_status got ld=%b rdy=%b expected 0 0", bus.loaded, bus.cfg_ready);
        end
    endtask

    task automatic test_basic_load();
        for (int i = 0; i < DEPTH; i++) pattern[i] = '0;
        pattern[14] = 1'b1; pattern[26] = 1'b1; pattern[30] = 1'b1;
        pattern[58] = 1'b1; pattern[62] = 1'b1;
        start_load();
        checks++;
        if (bus.busy !== 1'b1 || bus.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_entry got busy=%b rdy=%b expected 1 1", bus.busy, bus.cfg_ready);
        end
        send_words(DEPTH, DEPTH - 1);
        commit_model();
        checks++;
        if (bus.loaded !== 1'b1 || bus.err_len !== 1'b0 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_done got ld=%b err=%b busy=%b rdy=%b expected 1 0 0 0",
                     bus.loaded, bus.err_len, bus.busy, bus.cfg_ready);
        end
        checks++;
`ifdef LUT_CKSUM_EN
        if (bus.cksum !== 1'b1) begin
`else
        if (bus.cksum !== 1'b0) begin
`endif
            errors++;
            $display("FAIL cksum_basic got %h expected %h", bus.cksum, cur_ck);
        end
        query(6'h0E); query(6'h1A); query(6'h3E); query(6'h00); query(6'h3F);
        drain();
    endtask

    task automatic test_back_to_back();
        int t0, r0;
        t0 = rv_total;
        r0 = rv_rises;
        for (int a = 0; a < DEPTH; a++) query(a[IN_W-1:0]);
        drain();
        checks++;
        if (rv_total - t0 != DEPTH || rv_rises - r0 != 1) begin
            errors++;
            $display("FAIL back_to_back got %0d pulses in %0d runs expected 64 in 1",
                     rv_total - t0, rv_rises - r0);
        end
    endtask

    task automatic test_early_last();
        query(6'h0E);
        drain();
        start_load();
        send_words(11, 10);
        model_loaded = 1'b0;
        checks++;
        if (bus.loaded !== 1'b0 || bus.err_len !== 1'b1 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL early_last got ld=%b err=%b busy=%b rdy=%b expected 0 1 0 0",
                     bus.loaded, bus.err_len, bus.busy, bus.cfg_ready);
        end
        query(6'h1A);
        drain();
        checks++;
        if (bus.r_data !== 1'b1 || bus.cksum !== cur_ck) begin
            errors++;
            $display("FAIL early_last_hold got rd=%h ck=%h expected 1 %h", bus.r_data, bus.cksum, cur_ck);
        end
    endtask

    task automatic test_overrun();
        start_load();
        send_words(DEPTH, -1);
        checks++;
        if (bus.err_len !== 1'b1 || bus.loaded !== 1'b0 || bus.cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL overrun got err=%b ld=%b rdy=%b expected 1 0 0",
                     bus.err_len, bus.loaded, bus.cfg_ready);
        end
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 1'b1;
        repeat (2) tick();
        checks++;
        if (bus.cfg_ready !== 1'b0 || bus.busy !== 1'b0 || bus.err_len !== 1'b1 || bus.cksum !== cur_ck) begin
            errors++;
            $display("FAIL overrun_extra got rdy=%b busy=%b err=%b ck=%h expected 0 0 1 %h",
                     bus.cfg_ready, bus.busy, bus.err_len, bus.cksum, cur_ck);
        end
        bus.cfg_valid = 1'b0;
    endtask

    task automatic test_restart();
        for (int i = 0; i < DEPTH; i++) pattern[i] = OUT_W'($urandom_range(0, 1));
        if (pattern_xor() == '0) pattern[5] = ~pattern[5];
        start_load();
        send_words(20, -1);
        bus.load_start = 1'b1;
        bus.cfg_valid  = 1'b1;
        bus.cfg_data   = 1'b1;
        bus.cfg_last   = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.cfg_valid  = 1'b0;
        bus.cfg_last   = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.err_len !== 1'b0) begin
            errors++;
            $display("FAIL restart_state got busy=%b err=%b expected 1 0", bus.busy, bus.err_len);
        end
        send_words(DEPTH, DEPTH - 1);
        commit_model();
        checks++;
        if (bus.loaded !== 1'b1 || bus.err_len !== 1'b0 || bus.cksum !== cur_ck) begin
            errors++;
            $display("FAIL restart_done got ld=%b err=%b ck=%h expected 1 0 %h",
                     bus.loaded, bus.err_len, bus.cksum, cur_ck);
        end
        for (int a = DEPTH - 1; a >= 0; a--) query(a[IN_W-1:0]);
        drain();
    endtask

    task automatic test_reset_mid_load();
        start_load();
        send_words(5, -1);
        rst_n = 1'b0;
        #1;
        model_loaded = 1'b0;
        cur_ck = '0;
        checks++;
        if (bus.loaded !== 1'b0 || bus.cksum !== '0 || bus.busy !== 1'b0 ||
            bus.cfg_ready !== 1'b0 || bus.r_data !== '0) begin
            errors++;
            $display("FAIL async_reset got ld=%b ck=%h busy=%b rdy=%b rd=%h expected 0 0 0 0 0",
                     bus.loaded, bus.cksum, bus.busy, bus.cfg_ready, bus.r_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        query(6'h0E);
        drain();
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.cfg_valid  = 1'b0;
        bus.cfg_data   = '0;
        bus.cfg_last   = 1'b0;
        bus.q_valid    = 1'b0;
        bus.q_addr     = '0;
        test_reset();
        test_basic_load();
        test_back_to_back();
        test_early_last();
        test_overrun();
        test_restart();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
